// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

  localparam int unsigned MemWordAddrW = 6;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzRsvd = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoadWait,
    StRmwMerge,
    StStAck,
    StErrAck
  } lsu_state_e;

  // The reserved size is reported as misaligned so it never touches memory.
  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    logic mis;
    case (size)
      SzByte:  mis = 1'b0;
      SzHalf:  mis = off[0];
      SzWord:  mis = |off;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory signals of the load/store controller.
interface lsu_ctrl_if
  import lsu_pkg::*;
#(
  parameter int unsigned BYTE_ADDR_W = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [BYTE_ADDR_W-1:0]  req_addr;
  logic [31:0]             req_wdata;
  logic                    resp_valid;
  logic [31:0]             resp_rdata;
  logic                    resp_err;
  logic [MemWordAddrW-1:0] mem_address;
  logic [31:0]             mem_write_data;
  logic                    mem_we;
  logic [31:0]             mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_we
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [4:0]  sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] mask;

  assign sh      = {off_i, 3'b000};
  assign ld_byte = 8'(word_i >> sh);
  assign ld_half = 16'(word_i >> sh);

  always_comb begin
    rdata_o = word_i;
    mask    = 32'hFFFF_FFFF;
    unique case (size_i)
      SzByte: begin
        rdata_o = unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        mask    = 32'h0000_00FF << sh;
      end
      SzHalf: begin
        rdata_o = unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        mask    = 32'h0000_FFFF << sh;
      end
      default: begin
        rdata_o = word_i;
        mask    = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: word, halfword and byte accesses to a 64x32 synchronous memory.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned BYTE_ADDR_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  lsu_ctrl_if.slave  bus
);

  lsu_state_e              state_q, state_d;
  size_e                   size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;
  logic [MemWordAddrW-1:0] waddr_q, waddr_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [BYTE_ADDR_W-1:0]  req_addr;
  logic [MemWordAddrW-1:0] req_waddr;
  size_e                   req_size;
  logic [31:0]             ld_rdata;
  logic [31:0]             st_merged;

  // Upper address bits beyond the word index wrap modulo 64 words.
  assign req_addr  = bus.req_addr;
  assign req_waddr = req_addr[MemWordAddrW+1:2];
  assign req_size  = size_e'(bus.req_size);

  lsu_lane_align u_lane_align (
    .word_i     (bus.mem_read_data),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_o    (ld_rdata),
    .merged_o   (st_merged)
  );

  always_comb begin
    state_d            = state_q;
    size_d             = size_q;
    uns_d              = uns_q;
    off_d              = off_q;
    waddr_d            = waddr_q;
    wdata_d            = wdata_q;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_err       = 1'b0;
    bus.resp_rdata     = 32'h0;
    bus.mem_address    = '0;
    bus.mem_write_data = 32'h0;
    bus.mem_we         = 1'b0;

    // Reset forces every output quiet, including a pending RMW write.
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            size_d  = req_size;
            uns_d   = bus.req_unsigned;
            off_d   = req_addr[1:0];
            waddr_d = req_waddr;
            wdata_d = bus.req_wdata;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state_d = StErrAck;
            end else if (!bus.req_we) begin
              bus.mem_address = req_waddr;
              state_d         = StLoadWait;
            end else if (req_size == SzWord) begin
              bus.mem_address    = req_waddr;
              bus.mem_we         = 1'b1;
              bus.mem_write_data = bus.req_wdata;
              state_d            = StStAck;
            end else begin
              bus.mem_address = req_waddr;
              state_d         = StRmwMerge;
            end
          end
        end
        StLoadWait: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = ld_rdata;
          state_d        = StIdle;
        end
        StRmwMerge: begin
          bus.mem_address    = waddr_q;
          bus.mem_we         = 1'b1;
          bus.mem_write_data = st_merged;
          bus.resp_valid     = 1'b1;
          state_d            = StIdle;
        end
        StStAck: begin
          bus.resp_valid = 1'b1;
          state_d        = StIdle;
        end
        StErrAck: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = 1'b1;
          state_d        = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      size_q  <= SzByte;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 64x32 registered-read memory.
module tb_lsu_ctrl;

  logic clk;
  logic reset;
  logic preload;
  int   total;
  int   bad;

  lsu_ctrl_if #(.BYTE_ADDR_W(8)) bus ();

  lsu_ctrl #(.BYTE_ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h5555_ABCD;
    end else begin
      if (bus.mem_we) mem[bus.mem_address] <= bus.mem_write_data;
      bus.mem_read_data <= mem[bus.mem_address];
    end
  end

  // Observations from the accept cycle (a_*) and the response cycle (r_*).
  logic        a_we;
  logic [5:0]  a_addr;
  logic [31:0] a_wd;
  logic        r_valid, r_err, r_we;
  logic [5:0]  r_addr;
  logic [31:0] r_rdata, r_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wd);
    int n;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'h0, bus.req_ready}, 32'h1);
    a_we   = bus.mem_we;
    a_addr = bus.mem_address;
    a_wd   = bus.mem_write_data;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    r_valid = bus.resp_valid;
    r_err   = bus.resp_err;
    r_rdata = bus.resp_rdata;
    r_we    = bus.mem_we;
    r_addr  = bus.mem_address;
    r_wd    = bus.mem_write_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bb(input int i);
    case (i)
      0: begin bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 8'h30;
               bus.req_wdata = 32'h1111_1111; end
      1: begin bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 8'h30;
               bus.req_wdata = 32'h0; end
      2: begin bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_addr = 8'h31;
               bus.req_wdata = 32'hFFFF_FF22; end
      default: begin bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 8'h30;
               bus.req_wdata = 32'h0; end
    endcase
    bus.req_unsigned = 1'b0;
  endtask

  logic        bb_rdy [8];
  logic        bb_rv  [8];
  logic [31:0] bb_rd  [8];
  logic [31:0] bb_exp [8];

  initial begin
    int  idx;
    logic acc;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    preload = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 8'h0;
    bus.req_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Word store then load
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF);
    chk("sw_acc_we", {31'h0, a_we}, 32'h1);
    chk("sw_acc_addr", {26'h0, a_addr}, 32'd4);
    chk("sw_acc_wd", a_wd, 32'hDEAD_BEEF);
    chk("sw_rsp_valid", {31'h0, r_valid}, 32'h1);
    chk("sw_rsp_rdata", r_rdata, 32'h0);
    chk("sw_rsp_we", {31'h0, r_we}, 32'h0);
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);

    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    chk("lw_acc_we", {31'h0, a_we}, 32'h0);
    chk("lw_acc_addr", {26'h0, a_addr}, 32'd4);
    chk("lw_rsp_valid", {31'h0, r_valid}, 32'h1);
    chk("lw_rsp_rdata", r_rdata, 32'hDEAD_BEEF);

    // Byte RMW and sign/zero extension
    do_req(1'b1, 2'b00, 1'b0, 8'h12, 32'h1234_5680);
    chk("sb_acc_we", {31'h0, a_we}, 32'h0);
    chk("sb_acc_addr", {26'h0, a_addr}, 32'd4);
    chk("sb_rsp_we", {31'h0, r_we}, 32'h1);
    chk("sb_rsp_addr", {26'h0, r_addr}, 32'd4);
    chk("sb_rsp_wd", r_wd, 32'hDE80_BEEF);
    chk("sb_rsp_valid", {31'h0, r_valid}, 32'h1);
    chk("sb_mem", mem[4], 32'hDE80_BEEF);

    do_req(1'b0, 2'b00, 1'b0, 8'h12, 32'h0);
    chk("lb_signed", r_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b1, 8'h12, 32'h0);
    chk("lbu", r_rdata, 32'h0000_0080);
    do_req(1'b0, 2'b00, 1'b0, 8'h11, 32'h0);
    chk("lb_off1", r_rdata, 32'hFFFF_FFBE);

    // Halfword store and loads
    do_req(1'b1, 2'b01, 1'b0, 8'h16, 32'hAAAA_1234);
    chk("sh_rsp_wd", r_wd, 32'h1234_ABCD);
    chk("sh_mem", mem[5], 32'h1234_ABCD);
    do_req(1'b0, 2'b01, 1'b0, 8'h14, 32'h0);
    chk("lh_signed", r_rdata, 32'hFFFF_ABCD);
    do_req(1'b0, 2'b01, 1'b1, 8'h16, 32'h0);
    chk("lhu_upper", r_rdata, 32'h0000_1234);

    // Misaligned and reserved-size requests
    do_req(1'b0, 2'b10, 1'b0, 8'h11, 32'h0);
    chk("mis_lw_err", {31'h0, r_err}, 32'h1);
    chk("mis_lw_valid", {31'h0, r_valid}, 32'h1);
    chk("mis_lw_rdata", r_rdata, 32'h0);
    chk("mis_lw_we", {30'h0, a_we, r_we}, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 8'h13, 32'h0000_FFFF);
    chk("mis_sh_err", {31'h0, r_err}, 32'h1);
    chk("mis_sh_we", {30'h0, a_we, r_we}, 32'h0);
    chk("mis_sh_mem", mem[4], 32'hDE80_BEEF);
    do_req(1'b0, 2'b11, 1'b0, 8'h10, 32'h0);
    chk("rsv_err", {31'h0, r_err}, 32'h1);
    chk("rsv_rdata", r_rdata, 32'h0);
    chk("rsv_we", {30'h0, a_we, r_we}, 32'h0);

    // Reset in the merge cycle of a byte store
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 8'h20;
    bus.req_wdata = 32'h0000_0077;
    @(negedge clk);
    chk("rrmw_acc_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rrmw_acc_we", {31'h0, bus.mem_we}, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rrmw_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rrmw_resp", {31'h0, bus.resp_valid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rrmw_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rrmw_resp2", {31'h0, bus.resp_valid}, 32'h0);
    chk("rrmw_mem", mem[8], 32'h0);
    @(posedge clk);
    #1;

    // Back-to-back with req_valid held high
    bb_exp[1] = 32'h0;
    bb_exp[3] = 32'h1111_1111;
    bb_exp[5] = 32'h0;
    bb_exp[7] = 32'h1111_2211;
    idx = 0;
    drive_bb(0);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bb_rdy[c] = bus.req_ready;
      bb_rv[c]  = bus.resp_valid;
      bb_rd[c]  = bus.resp_rdata;
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) drive_bb(idx);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("bb_ready_%0d", c), {31'h0, bb_rdy[c]}, {31'h0, (c % 2) == 0});
      chk($sformatf("bb_rvalid_%0d", c), {31'h0, bb_rv[c]}, {31'h0, (c % 2) == 1});
      if (c % 2 == 1) chk($sformatf("bb_rdata_%0d", c), bb_rd[c], bb_exp[c]);
    end
    chk("bb_accepted", idx, 32'd4);
    chk("bb_mem", mem[12], 32'h1111_2211);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store controller between the ALU/pipeline stage and the word-wide data memory (64 words × 32 bit, synchronous 1-cycle registered read, write-enable `we2`).
- Accepts byte-addressed load/store requests of byte, halfword or word size.
- Drives the memory's word address, write data and write enable.
- Performs read-modify-write for sub-word stores, sign/zero-extends sub-word loads, and flags misaligned accesses.

Parameters:
- BYTE_ADDR_W, 8: request byte-address width. Word address is bits [BYTE_ADDR_W-1:2], 6 bits at default.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; request taken when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  BYTE_ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse, one per accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned/reserved-size request; no memory access made.
- mem_address  out  6  word address to data memory.
- mem_write_data  out  32  word written to data memory.
- mem_we  out  1  memory write enable.
- mem_read_data  in  32  memory registered read data, valid the cycle after the address is presented with mem_we=0.

Behaviour:
- FSM states: IDLE, LOAD_WAIT, RMW_MERGE, ST_ACK, ERR_ACK.
- req_ready = 1 only in IDLE. Accepted request fields (we, size, unsigned, addr[1:0], word address, wdata) are latched at acceptance.
- Memory outputs are combinational from state and request/latched fields, so the memory samples them in the same cycle.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; size=11.
  - On accept: mem_we=0, -> ERR_ACK.
  - ERR_ACK: resp_valid=1, resp_err=1, resp_rdata=0 -> IDLE.
- Load (aligned):
  - Accept cycle: mem_address=req_addr[7:2], mem_we=0 -> LOAD_WAIT.
  - LOAD_WAIT: select lane from mem_read_data (byte k = bits [8k+7:8k], little-endian; half at addr[1]), extend per latched unsigned flag; resp_valid=1 -> IDLE.
- Word store: accept cycle drives mem_we=1, mem_write_data=req_wdata -> ST_ACK.
  - ST_ACK: resp_valid=1, rdata 0 -> IDLE.
- Sub-word store (RMW):
  - Accept cycle: read word, mem_we=0 -> RMW_MERGE.
  - RMW_MERGE: mem_address=latched word address, mem_we=1, mem_write_data = mem_read_data with the target lane(s) replaced by latched wdata; resp_valid=1 -> IDLE.
- Latency: every accepted request gets exactly one resp_valid, exactly 1 cycle after acceptance. Maximum throughput is 1 request per 2 cycles.
- Outside the cycles listed above: mem_we=0, and mem_address / mem_write_data are 0.
- Reset:
  - state -> IDLE; latched fields cleared.
  - In a reset cycle: mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0.
  - Reset during LOAD_WAIT or RMW_MERGE aborts the operation: no response and no write is issued. Reset has priority over all other inputs.
- req_valid while not in IDLE is ignored; the requester holds it.
- Address bits above the word address do not exist at default width. Wider BYTE_ADDR_W truncates to the 6-bit word index (wrap modulo 64 words).

Decomposition:
- Shared package lsu_pkg:
  - size enum (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10).
  - FSM state enum.
  - MEM_WORD_ADDR_W=6 constant.
- One natural sub-module: lsu_lane_align, purely combinational.
  - Load extract/extend: mem word, addr[1:0], size, unsigned -> rdata.
  - Store merge: old word, wdata, addr[1:0], size -> new word.
- FSM stays in lsu_ctrl.

Test Plan:
- Word store/load: store 0xDEADBEEF at addr 0x10 → mem_we=1 at word 4 in the accept cycle, resp_valid next cycle. Load word 0x10 → resp_rdata=0xDEADBEEF one cycle after accept.
- Byte RMW + sign: word 4 = 0xDEADBEEF; store byte 0x80 at addr 0x12 → written word 0xDE80BEEF. Signed byte load 0x12 → 0xFFFFFF80; unsigned → 0x00000080.
- Half: store half 0x1234 at addr 0x16 → word 5 upper half = 0x1234, lower half unchanged. Signed half load 0x14 returns the lower half, e.g. 0xABCD → 0xFFFFABCD.
- Misaligned: word load at 0x11, half store at 0x13, size=11 → each gives resp_valid with resp_err=1 one cycle later, mem_we never asserted, memory contents unchanged.
- Reset mid-RMW: byte store accepted, reset asserted the next cycle → no mem_we, no resp_valid, req_ready=1 the cycle after reset deasserts.
- Back-to-back: req_valid held high with 4 requests → accepted every other cycle, req_ready low in each response cycle, 4 resp_valid pulses in order.
